csi2_packet_transmitter: RTL and testbench

- Transmit-side CSI-2 low-level protocol packetizer.
- Accepts packet requests (virtual channel, data type, word count) and a payload byte stream.
- Builds short packets or long packets. A long packet is header + payload + CRC-16 footer.
- Distributes packet bytes round-robin across NUM_LANES per-lane byte outputs that feed the D-PHY lane transmitters. It is the camera-side counterpart of the lane receivers and packet parser.

---
 rtl/csi2_packet_transmitter.sv | 216 +++++++++++++++++++++
 tb/tb_csi2_packet_transmitter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_packet_transmitter.sv
// csi2_packet_transmitter
//
// Transmit-side CSI-2 low-level packetizer. A request (VC, DT, WC) turns into
// a byte stream: header DI, WC lo, WC hi, ECC, then for long packets WC
// payload bytes and CRC lo, CRC hi. Stream byte n is placed on lane
// (n mod NUM_LANES) in beat floor(n / NUM_LANES). Beat 0 is the cycle after
// acceptance. Every packet is followed by GAP_CYCLES idle cycles.
//
// Ports
//   clock, reset            byte clock, synchronous active-high reset
//   packet_start            request strobe, taken when packet_start && packet_ready
//   packet_ready            high only while idle
//   packet_virtual_channel  VC captured on acceptance
//   packet_data_type        DT captured on acceptance (0x00-0x0F = short packet)
//   packet_word_count       payload length (long) or data field (short)
//   payload_data            NUM_LANES payload bytes, byte k on [8k+7:8k]
//   payload_valid           payload beat valid
//   payload_ready           a payload beat is consumed this cycle
//   lane_data               lane i byte on [8i+7:8i]
//   lane_valid              per-lane HS byte valid
//   underflow               sticky: payload_ready seen without payload_valid
//   dbg_state               current FSM state
//
// Handshake semantics: a request is transferred on any cycle where
// packet_start && packet_ready. payload_ready is not a request but an
// obligation: HS transmission cannot stall, so a payload beat is consumed on
// every payload_ready cycle whether or not payload_valid is high; a missing
// beat is replaced by zero bytes and flagged through underflow.

module csi2_packet_transmitter #(
    parameter int NUM_LANES  = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   packet_start,
    output logic                   packet_ready,
    input  logic [1:0]             packet_virtual_channel,
    input  logic [5:0]             packet_data_type,
    input  logic [15:0]            packet_word_count,
    input  logic [8*NUM_LANES-1:0] payload_data,
    input  logic                   payload_valid,
    output logic                   payload_ready,
    output logic [8*NUM_LANES-1:0] lane_data,
    output logic [NUM_LANES-1:0]   lane_valid,
    output logic                   underflow,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_FOOTER  = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    // CSI-2 ECC: 6 Hamming parity bits over {WC, DI}, top two bits zero.
    function automatic logic [7:0] ecc_gen(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^
               d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^
               d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^
               d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^
               d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return {2'b00, p};
    endfunction

    // CRC-16 x^16+x^12+x^5+1, reflected (bit 0 of each byte first).
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int k = 0; k < 8; k++) begin
            if (c[0] ^ data[k]) c = (c >> 1) ^ 16'h8408;
            else                c = c >> 1;
        end
        return c;
    endfunction

    state_t                 state_q;
    logic [16:0]            pos_q;          // stream index of this beat's lane-0 byte
    logic [16:0]            len_q;          // total stream length in bytes
    logic [15:0]            wc_q;
    logic [31:0]            hdr_q;          // DI, WC lo, WC hi, ECC from byte 0 up
    logic [15:0]            crc_q;
    logic [15:0]            gap_q;
    logic                   packet_ready_q;
    logic                   payload_ready_q;
    logic                   underflow_q;

    logic [16:0]            pos_d;
    logic [16:0]            pay_end;
    logic [15:0]            crc_d;
    logic [8*NUM_LANES-1:0] lane_data_d;
    logic [NUM_LANES-1:0]   lane_valid_d;
    logic                   beat_active;

    assign pos_d       = pos_q + 17'(NUM_LANES);
    assign pay_end     = 17'd4 + {1'b0, wc_q};
    assign beat_active = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD) ||
                         (state_q == ST_FOOTER);

    // Beat builder. The header length is a multiple of NUM_LANES, so payload
    // byte j always sits on lane (j mod NUM_LANES) of the input beat. The CRC
    // is chained through the payload lanes in order so CRC bytes sharing a
    // beat with the last payload byte already include it.
    always_comb begin : beat_build
        logic [16:0] p;
        logic [7:0]  b;
        p            = '0;
        b            = '0;
        crc_d        = crc_q;
        lane_data_d  = '0;
        lane_valid_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            p = pos_q + 17'(i);
            b = 8'h00;
            if (beat_active && (p < len_q)) begin
                lane_valid_d[i] = 1'b1;
                if (p < 17'd4) begin
                    b = hdr_q[{p[1:0], 3'b000} +: 8];
                end else if (p < pay_end) begin
                    b     = payload_valid ? payload_data[8*i +: 8] : 8'h00;
                    crc_d = crc16_byte(crc_d, b);
                end else if (p == pay_end) begin
                    b = crc_d[7:0];
                end else begin
                    b = crc_d[15:8];
                end
                lane_data_d[8*i +: 8] = b;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            pos_q           <= '0;
            len_q           <= '0;
            wc_q            <= '0;
            hdr_q           <= '0;
            crc_q           <= 16'hFFFF;
            gap_q           <= '0;
            packet_ready_q  <= 1'b1;
            payload_ready_q <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            underflow_q <= underflow_q | (payload_ready_q & ~payload_valid);
            case (state_q)
                ST_IDLE: begin
                    if (packet_start) begin
                        state_q         <= ST_HEADER;
                        pos_q           <= '0;
                        crc_q           <= 16'hFFFF;
                        wc_q            <= packet_word_count;
                        hdr_q           <= {ecc_gen({packet_word_count, packet_virtual_channel,
                                                     packet_data_type}),
                                            packet_word_count,
                                            packet_virtual_channel, packet_data_type};
                        len_q           <= (packet_data_type <= 6'h0F) ? 17'd4
                                           : ({1'b0, packet_word_count} + 17'd6);
                        packet_ready_q  <= 1'b0;
                        payload_ready_q <= 1'b0;
                    end
                end
                ST_HEADER, ST_PAYLOAD, ST_FOOTER: begin
                    crc_q <= crc_d;
                    pos_q <= pos_d;
                    // The next state names the role of the next beat's lane-0 byte.
                    if (pos_d >= len_q) begin
                        state_q         <= ST_GAP;
                        gap_q           <= 16'(GAP_CYCLES - 1);
                        payload_ready_q <= 1'b0;
                    end else if (pos_d < 17'd4) begin
                        state_q         <= ST_HEADER;
                        payload_ready_q <= 1'b0;
                    end else if (pos_d < pay_end) begin
                        state_q         <= ST_PAYLOAD;
                        payload_ready_q <= 1'b1;
                    end else begin
                        state_q         <= ST_FOOTER;
                        payload_ready_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 16'd0) begin
                        state_q        <= ST_IDLE;
                        packet_ready_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 16'd1;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    packet_ready_q  <= 1'b1;
                    payload_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign packet_ready  = packet_ready_q;
    assign payload_ready = payload_ready_q;
    assign lane_data     = lane_data_d;
    assign lane_valid    = lane_valid_d;
    assign underflow     = underflow_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_csi2_packet_transmitter.sv
module tb_csi2_packet_transmitter;
  localparam int NL  = 2;
  localparam int GAP = 2;
  localparam int W   = 8 * NL;
  localparam int EW  = NL + W + 3;

  logic          clock;
  logic          reset;
  logic          packet_start;
  logic          packet_ready;
  logic [1:0]    packet_virtual_channel;
  logic [5:0]    packet_data_type;
  logic [15:0]   packet_word_count;
  logic [W-1:0]  payload_data;
  logic          payload_valid;
  logic          payload_ready;
  logic [W-1:0]  lane_data;
  logic [NL-1:0] lane_valid;
  logic          underflow;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // expected per-cycle outputs: {lane_valid, lane_data, packet_ready, payload_ready, underflow}
  logic [EW-1:0] exp_q[$];
  logic [7:0]    pay_q[$];
  logic [7:0]    stm_q[$];
  logic [7:0]    fixed_pay[$];
  logic [15:0]   crc_tbl[256];
  logic          uf_m;

  // syndrome column of each data bit D0..D23 in the CSI-2 ECC table
  logic [5:0] ecc_col[24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                              6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                              6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  csi2_packet_transmitter #(.NUM_LANES(NL), .GAP_CYCLES(GAP)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .packet_start           (packet_start),
    .packet_ready           (packet_ready),
    .packet_virtual_channel (packet_virtual_channel),
    .packet_data_type       (packet_data_type),
    .packet_word_count      (packet_word_count),
    .payload_data           (payload_data),
    .payload_valid          (payload_valid),
    .payload_ready          (payload_ready),
    .lane_data              (lane_data),
    .lane_valid             (lane_valid),
    .underflow              (underflow),
    .dbg_state              (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [7:0] ecc_model(input logic [23:0] d);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 24; i++) if (d[i]) s ^= ecc_col[i];
    return {2'b00, s};
  endfunction

  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pay_q[j]) c = (c >> 8) ^ crc_tbl[c[7:0] ^ pay_q[j]];
    return c;
  endfunction

  task automatic push_exp(input logic [NL-1:0] lv, input logic [W-1:0] ld, input logic prdy,
                          input logic pyrdy, input logic uf);
    exp_q.push_back({lv, ld, prdy, pyrdy, uf});
  endtask

  // scoreboard compare, away from the active edge
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("lane_valid",    64'(lane_valid),    64'(e[EW-1 -: NL]));
      chk("lane_data",     64'(lane_data),     64'(e[W+2 -: W]));
      chk("packet_ready",  64'(packet_ready),  64'(e[2]));
      chk("payload_ready", 64'(payload_ready), 64'(e[1]));
      chk("underflow",     64'(underflow),     64'(e[0]));
    end
  end

  task automatic drive_garbage();
    packet_start           = ($urandom_range(0, 2) == 0);
    packet_virtual_channel = 2'($urandom());
    packet_data_type       = 6'($urandom());
    packet_word_count      = 16'($urandom());
    payload_data           = W'($urandom());
    payload_valid          = 1'($urandom_range(0, 1));
  endtask

  // driver: one request, its beats, gap and the following idle cycle
  task automatic send_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                             input int bad_beat, input int abort_beat, input bit use_fixed);
    bit            is_long;
    int            nbp;
    int            len;
    int            nb;
    int            k;
    int            n;
    logic [W-1:0]  bdata[$];
    bit            bvalid[$];
    logic [W-1:0]  tmp;
    logic [W-1:0]  ld;
    logic [NL-1:0] lv;
    logic [15:0]   crc;
    bit            pyrdy;

    is_long = (dt > 6'h0F);
    nbp = is_long ? (int'(wc) + NL - 1) / NL : 0;
    for (int b = 0; b < nbp; b++) begin
      tmp = W'($urandom());
      if (use_fixed)
        for (int i = 0; i < NL; i++)
          if (b * NL + i < fixed_pay.size()) tmp[8*i +: 8] = fixed_pay[b * NL + i];
      bdata.push_back(tmp);
      bvalid.push_back(b != bad_beat);
    end

    pay_q.delete();
    if (is_long)
      for (int j = 0; j < int'(wc); j++) begin
        tmp = bdata[j / NL];
        pay_q.push_back(bvalid[j / NL] ? tmp[8*(j % NL) +: 8] : 8'h00);
      end

    stm_q.delete();
    stm_q.push_back({vc, dt});
    stm_q.push_back(wc[7:0]);
    stm_q.push_back(wc[15:8]);
    stm_q.push_back(ecc_model({wc, vc, dt}));
    if (is_long) begin
      foreach (pay_q[j]) stm_q.push_back(pay_q[j]);
      crc = crc_model();
      stm_q.push_back(crc[7:0]);
      stm_q.push_back(crc[15:8]);
    end
    len = stm_q.size();
    nb  = (len + NL - 1) / NL;

    @(posedge clock); #1;
    packet_start           = 1'b1;
    packet_virtual_channel = vc;
    packet_data_type       = dt;
    packet_word_count      = wc;
    payload_data           = W'($urandom());
    payload_valid          = 1'b0;
    push_exp('0, '0, 1'b1, 1'b0, uf_m);

    k = 0;
    for (int b = 0; b < nb; b++) begin
      lv    = '0;
      ld    = '0;
      pyrdy = 1'b0;
      for (int i = 0; i < NL; i++) begin
        n = b * NL + i;
        if (n < len) begin
          lv[i]         = 1'b1;
          ld[8*i +: 8]  = stm_q[n];
          if (is_long && n >= 4 && n < 4 + int'(wc)) pyrdy = 1'b1;
        end
      end
      @(posedge clock); #1;
      drive_garbage();
      if (pyrdy) begin
        payload_data  = bdata[k];
        payload_valid = bvalid[k];
      end
      if (b == abort_beat) reset = 1'b1;
      push_exp(lv, ld, 1'b0, pyrdy, uf_m);
      if (pyrdy) begin
        if (!bvalid[k]) uf_m = 1'b1;
        k++;
      end
      if (b == abort_beat) begin
        @(posedge clock); #1;
        reset         = 1'b0;
        packet_start  = 1'b0;
        payload_valid = 1'b0;
        uf_m          = 1'b0;
        push_exp('0, '0, 1'b1, 1'b0, 1'b0);
        return;
      end
    end

    for (int g = 0; g < GAP; g++) begin
      @(posedge clock); #1;
      drive_garbage();
      push_exp('0, '0, 1'b0, 1'b0, uf_m);
    end

    @(posedge clock); #1;
    packet_start  = 1'b0;
    payload_valid = 1'b0;
    push_exp('0, '0, 1'b1, 1'b0, uf_m);
  endtask

  // stimulus and final report
  initial begin
    int          nbp;
    int          bad;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [15:0] c;

    for (int b = 0; b < 256; b++) begin
      c = 16'(b);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      crc_tbl[b] = c;
    end

    reset                  = 1'b1;
    packet_start           = 1'b0;
    packet_virtual_channel = '0;
    packet_data_type       = '0;
    packet_word_count      = '0;
    payload_data           = '0;
    payload_valid          = 1'b0;
    uf_m                   = 1'b0;

    // pin the model to hand-computed values
    chk("ecc_pin_di01", 64'(ecc_model(24'h000001)), 64'h07);
    chk("ecc_pin_zero", 64'(ecc_model(24'h000000)), 64'h00);
    fixed_pay = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                  8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                  8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    pay_q = fixed_pay;
    chk("crc_pin_vector", 64'(crc_model()), 64'h00F0);
    pay_q.delete();
    chk("crc_pin_empty", 64'(crc_model()), 64'hFFFF);

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    push_exp('0, '0, 1'b1, 1'b0, 1'b0);

    send_packet(2'd0, 6'h01, 16'h0000, -1, -1, 1'b0);
    send_packet(2'd0, 6'h00, 16'h0000, -1, -1, 1'b0);
    send_packet(2'd0, 6'h2A, 16'd24,   -1, -1, 1'b1);
    send_packet(2'd1, 6'h12, 16'd5,    -1, -1, 1'b0);
    send_packet(2'd3, 6'h30, 16'd0,    -1, -1, 1'b0);
    send_packet(2'd2, 6'h2B, 16'd9,     1, -1, 1'b0);
    send_packet(2'd0, 6'h2C, 16'd6,    -1, -1, 1'b0);
    send_packet(2'd1, 6'h2A, 16'd20,   -1, 4 / NL + 2, 1'b0);
    send_packet(2'd1, 6'h05, 16'h1234, -1, -1, 1'b0);

    repeat (30) begin
      dt  = 6'($urandom_range(0, 63));
      wc  = (dt <= 6'h0F) ? 16'($urandom()) : 16'($urandom_range(0, 40));
      nbp = (dt <= 6'h0F) ? 0 : (int'(wc) + NL - 1) / NL;
      bad = (nbp > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, nbp - 1) : -1;
      send_packet(2'($urandom()), dt, wc, bad, -1, 1'b0);
    end
    send_packet(2'd2, 6'h24, 16'd300, -1, -1, 1'b0);

    repeat (2) @(posedge clock);
    #1;
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
